// File: rtl/cor_pkg.sv
// Shared types, default widths and pointer helper for the correlation sweep datapath.
package cor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned BUF_SIZE_DEF     = 500;
  localparam int          BUF_SIZE_MSB_DEF = 8;
  localparam int          ADC_MSB_DEF      = 11;
  localparam int          COEF_MSB_DEF     = 11;
  localparam int          ACC_MSB_DEF      = 35;

  // Circular increment for windows whose length is not a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
    return (ptr + 32'd1 >= size) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/cor_mac.sv
// Registered signed multiply-accumulate: unsigned sample times signed coefficient.
module cor_mac
  import cor_pkg::*;
#(
  parameter int ADC_MSB  = ADC_MSB_DEF,
  parameter int COEF_MSB = COEF_MSB_DEF,
  parameter int ACC_MSB  = ACC_MSB_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [ADC_MSB:0]  sample_i,
  input  logic [COEF_MSB:0] coef_i,
  output logic [ACC_MSB:0]  acc_o
);

  localparam int PROD_W = ADC_MSB + COEF_MSB + 3;

  logic signed [PROD_W-1:0] a_w;
  logic signed [PROD_W-1:0] b_w;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_MSB:0]         prod_ext;
  logic [ACC_MSB:0]         acc_q;
  logic [ACC_MSB:0]         acc_d;

  // Sample gets a zero sign bit so it stays non-negative in the signed product.
  assign a_w      = {{(PROD_W-ADC_MSB-1){1'b0}}, sample_i};
  assign b_w      = {{(PROD_W-COEF_MSB-1){coef_i[COEF_MSB]}}, coef_i};
  assign prod     = a_w * b_w;
  assign prod_ext = {{(ACC_MSB+1-PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Exposes the sum including this cycle's product so the final total is capturable on the last enable.
  assign acc_o = acc_d;

endmodule

// File: rtl/cor_sweep_ctrl.sv
// Sequencer around the circular sample window: writes samples, sweeps oldest-to-newest, emits correlations.
module cor_sweep_ctrl
  import cor_pkg::*;
#(
  parameter int unsigned BUF_SIZE     = BUF_SIZE_DEF,
  parameter int          BUF_SIZE_MSB = BUF_SIZE_MSB_DEF,
  parameter int          ADC_MSB      = ADC_MSB_DEF,
  parameter int          COEF_MSB     = COEF_MSB_DEF,
  parameter int          ACC_MSB      = ACC_MSB_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [ADC_MSB:0]      sample,
  output logic                  sample_ready,
  output logic                  buf_write,
  output logic [BUF_SIZE_MSB:0] buf_wr_addr,
  output logic [ADC_MSB:0]      buf_wr_data,
  output logic [BUF_SIZE_MSB:0] buf_rd_addr,
  input  logic [ADC_MSB:0]      buf_val,
  output logic [BUF_SIZE_MSB:0] coef_addr,
  input  logic [COEF_MSB:0]     coef_val,
  output logic [ACC_MSB:0]      cor_val,
  output logic                  cor_valid,
  output logic                  primed,
  output logic                  overrun
);

  localparam int ADDR_W = BUF_SIZE_MSB + 1;
  localparam int FILL_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BUF_SIZE - 1);
  localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(BUF_SIZE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              primed_q, primed_d;
  logic              overrun_q, overrun_d;
  logic              cor_valid_q, cor_valid_d;
  logic [ACC_MSB:0]  cor_val_q, cor_val_d;
  logic [ACC_MSB:0]  mac_sum;
  logic              accept;
  logic              mac_en;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(wrap_inc(32'(a), BUF_SIZE));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SWEEP;
      SWEEP:   if (idx_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-side outputs are gated by rst_n so nothing leaks to the buffer while reset is held.
  always_comb begin
    sample_ready = 1'b0;
    buf_write    = 1'b0;
    buf_wr_addr  = '0;
    buf_wr_data  = '0;
    buf_rd_addr  = '0;
    coef_addr    = '0;
    accept       = 1'b0;
    mac_en       = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready = 1'b1;
        accept       = sample_valid;
        buf_write    = sample_valid & rst_n;
        buf_wr_addr  = wr_ptr_q;
        buf_wr_data  = rst_n ? sample : '0;
      end
      SWEEP: begin
        buf_rd_addr = rd_ptr_q;
        coef_addr   = idx_q;
        mac_en      = (idx_q != '0);
      end
      DRAIN: begin
        mac_en = 1'b1;
      end
      default: ;
    endcase
  end

  // The sweep starts just past the newest sample, so the newest one is read last.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    if (accept) begin
      wr_ptr_d = next_addr(wr_ptr_q);
      rd_ptr_d = next_addr(wr_ptr_q);
      idx_d    = '0;
      if (fill_q != FULL_CNT) fill_d = fill_q + FILL_W'(1);
    end else if (state_q == SWEEP) begin
      rd_ptr_d = next_addr(rd_ptr_q);
      idx_d    = idx_q + ADDR_W'(1);
    end
    primed_d    = primed_q | (fill_d == FULL_CNT);
    overrun_d   = overrun_q | (sample_valid && (state_q != IDLE));
    cor_val_d   = (state_q == DRAIN) ? mac_sum : cor_val_q;
    cor_valid_d = (state_q == DRAIN) && primed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      overrun_q   <= 1'b0;
      cor_val_q   <= '0;
      cor_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      overrun_q   <= overrun_d;
      cor_val_q   <= cor_val_d;
      cor_valid_q <= cor_valid_d;
    end
  end

  cor_mac #(
    .ADC_MSB  (ADC_MSB),
    .COEF_MSB (COEF_MSB),
    .ACC_MSB  (ACC_MSB)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .en_i     (mac_en),
    .sample_i (buf_val),
    .coef_i   (coef_val),
    .acc_o    (mac_sum)
  );

  assign cor_val   = cor_val_q;
  assign cor_valid = cor_valid_q;
  assign primed    = primed_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cor_sweep_ctrl.sv
// Scoreboard bench: a 4-entry window exercised with directed samples, plus a full-size arithmetic corner.
module tb_cor_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        sample_valid;
  logic [11:0] sample;
  logic        sample_ready;
  logic        buf_write;
  logic [2:0]  buf_wr_addr;
  logic [11:0] buf_wr_data;
  logic [2:0]  buf_rd_addr;
  logic [11:0] buf_val;
  logic [2:0]  coef_addr;
  logic [11:0] coef_val;
  logic [35:0] cor_val;
  logic        cor_valid;
  logic        primed;
  logic        overrun;

  logic        b_sample_valid;
  logic [11:0] b_sample;
  logic        b_sample_ready;
  logic        b_buf_write;
  logic [8:0]  b_buf_wr_addr;
  logic [11:0] b_buf_wr_data;
  logic [8:0]  b_buf_rd_addr;
  logic [11:0] b_buf_val;
  logic [8:0]  b_coef_addr;
  logic [11:0] b_coef_val;
  logic [35:0] b_cor_val;
  logic        b_cor_valid;
  logic        b_primed;
  logic        b_overrun;

  cor_sweep_ctrl #(.BUF_SIZE(4), .BUF_SIZE_MSB(2), .ADC_MSB(11), .COEF_MSB(11), .ACC_MSB(35)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
    .sample_ready(sample_ready), .buf_write(buf_write), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .buf_rd_addr(buf_rd_addr), .buf_val(buf_val),
    .coef_addr(coef_addr), .coef_val(coef_val), .cor_val(cor_val), .cor_valid(cor_valid),
    .primed(primed), .overrun(overrun)
  );

  cor_sweep_ctrl #(.BUF_SIZE(500), .BUF_SIZE_MSB(8), .ADC_MSB(11), .COEF_MSB(11), .ACC_MSB(35)) dut_big (
    .clk(clk), .rst_n(rst_n), .sample_valid(b_sample_valid), .sample(b_sample),
    .sample_ready(b_sample_ready), .buf_write(b_buf_write), .buf_wr_addr(b_buf_wr_addr),
    .buf_wr_data(b_buf_wr_data), .buf_rd_addr(b_buf_rd_addr), .buf_val(b_buf_val),
    .coef_addr(b_coef_addr), .coef_val(b_coef_val), .cor_val(b_cor_val), .cor_valid(b_cor_valid),
    .primed(b_primed), .overrun(b_overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit big_seen = 1'b0;

  typedef struct {
    logic signed [35:0] val;
    int                 cyc;
  } exp_t;
  exp_t sb_q[$];

  // Environment: circular buffer RAM and coefficient ROM, both with one cycle read latency.
  logic [11:0] mem [8];
  logic [11:0] coef_rom [4];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (buf_write) mem[buf_wr_addr] <= buf_wr_data;
    buf_val   <= mem[buf_rd_addr];
    coef_val  <= coef_rom[coef_addr[1:0]];
    b_buf_val  <= 12'hFFF;
    b_coef_val <= 12'h800;
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!sample_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", sample_ready, 1);
  endtask

  task automatic send(input logic [11:0] v, input logic [2:0] addr, input bit expect_res,
                      input logic signed [35:0] ev);
    wait_idle();
    sample_valid = 1'b1;
    sample       = v;
    #1;
    check("buf_write", buf_write, 1);
    check("wr_addr", buf_wr_addr, addr);
    check("wr_data", buf_wr_data, v);
    if (expect_res) sb_q.push_back('{ev, cyc + 6});
    $display("send sample=%0d addr=%0d expect=%0d", v, addr, expect_res ? ev : 0);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sample       = '0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cor_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", cor_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("cor_val", $signed(cor_val), e.val);
          check("latency", cyc, e.cyc);
          check("ready_with_valid", sample_ready, 1);
          $display("result cor_val=%0d cycle=%0d", $signed(cor_val), cyc);
        end
      end
      if (buf_write && buf_wr_addr > 3) check("wr_addr_range", buf_wr_addr, 3);
      if (buf_rd_addr > 3) check("rd_addr_range", buf_rd_addr, 3);
      if (b_cor_valid) big_seen = 1'b1;
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    b_sample_valid = 1'b0;
    b_sample = '0;
    for (int i = 0; i < 4; i++) coef_rom[i] = 12'd1;
    repeat (3) @(negedge clk);
    check("rst_ready", sample_ready, 1);
    check("rst_write", buf_write, 0);
    check("rst_cor_valid", cor_valid, 0);
    check("rst_cor_val", cor_val, 0);
    check("rst_primed", primed, 0);
    check("rst_overrun", overrun, 0);
    check("rst_big_ready", b_sample_ready, 1);
    rst_n = 1'b1;

    send(12'd1, 3'd0, 1'b0, 0);
    send(12'd2, 3'd1, 1'b0, 0);
    send(12'd3, 3'd2, 1'b0, 0);
    check("primed_after_3", primed, 0);
    send(12'd4, 3'd3, 1'b1, 10);
    check("primed_after_4", primed, 1);
    send(12'd5, 3'd0, 1'b1, 14);
    wait_idle();

    coef_rom[0] = 12'd1;
    coef_rom[1] = 12'd0;
    coef_rom[2] = 12'd0;
    coef_rom[3] = 12'hFFF;
    send(12'd10, 3'd1, 1'b1, -7);
    send(12'd20, 3'd2, 1'b1, -16);
    send(12'd30, 3'd3, 1'b1, -25);
    send(12'd40, 3'd0, 1'b1, -30);

    send(12'd7, 3'd1, 1'b1, 13);
    check("overrun_before", overrun, 0);
    @(negedge clk);
    sample_valid = 1'b1;
    sample = 12'd99;
    #1;
    check("busy_no_write", buf_write, 0);
    check("busy_not_ready", sample_ready, 0);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sample = '0;
    check("overrun_set", overrun, 1);
    send(12'd8, 3'd2, 1'b1, 22);

    send(12'd9, 3'd3, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", buf_write, 0);
    check("mid_rst_wr_addr", buf_wr_addr, 0);
    check("mid_rst_wr_data", buf_wr_data, 0);
    check("mid_rst_rd_addr", buf_rd_addr, 0);
    check("mid_rst_coef_addr", coef_addr, 0);
    check("mid_rst_cor_val", cor_val, 0);
    check("mid_rst_cor_valid", cor_valid, 0);
    check("mid_rst_primed", primed, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_ready", sample_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_primed", primed, 0);
    check("post_rst_wr_addr", buf_wr_addr, 0);

    send(12'd1, 3'd0, 1'b0, 0);
    send(12'd2, 3'd1, 1'b0, 0);
    send(12'd3, 3'd2, 1'b0, 0);
    send(12'd4, 3'd3, 1'b1, -3);
    wait_idle();
    check("scoreboard_empty", sb_q.size(), 0);

    @(negedge clk);
    b_sample_valid = 1'b1;
    b_sample = 12'hFFF;
    #1;
    check("big_write", b_buf_write, 1);
    @(posedge clk);
    #1;
    b_sample_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!b_sample_ready && t < 700) begin
      @(negedge clk);
      t++;
    end
    check("big_ready_wait", b_sample_ready, 1);
    check("big_cor_val", $signed(b_cor_val), -64'sd4193280000);
    check("big_no_valid", big_seen, 0);
    check("big_primed", b_primed, 0);
    $display("big sweep cor_val=%0d after %0d cycles", $signed(b_cor_val), t + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
